// File: rtl/cache_controller_nway.sv
// N-way set-associative write-through, no-write-allocate data cache between the MEM stage and a 64-bit SRAM.
// True-LRU by per-way ages, global invalidate, saturating load hit/miss counters.
module cache_controller_nway #(
  parameter int ADDR_W = 32,
  parameter int WAYS   = 2,
  parameter int SETS   = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       wdata,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic              inv,
  output logic [31:0]       rdata,
  output logic              ready,
  output logic [31:0]       sram_address,
  output logic [31:0]       sram_wdata,
  output logic              sram_read,
  output logic              sram_write,
  input  logic [63:0]       sram_rdata,
  input  logic              sram_ready,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 3 - IDX_W;
  localparam int AGE_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR} state_t;
  state_t state, state_nx;

  logic [SETS-1:0][WAYS-1:0]             valid;
  logic [SETS-1:0][WAYS-1:0][AGE_W-1:0]  ages;
  logic [TAG_W-1:0]                      tags  [SETS][WAYS];
  logic [63:0]                           lines [SETS][WAYS];

  logic             word;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             unused_bits;
  assign word        = address[2];
  assign idx         = address[3 +: IDX_W];
  assign tag         = address[ADDR_W-1 -: TAG_W];
  assign unused_bits = ^address[1:0];

  // Per-way tag compare
  logic [WAYS-1:0] way_hit;
  for (genvar g = 0; g < WAYS; g++) begin : g_cmp
    assign way_hit[g] = valid[idx][g] && (tags[idx][g] == tag);
  end

  logic             hit;
  logic [AGE_W-1:0] hit_way, victim;
  logic [63:0]      hit_line;
  logic [31:0]      hit_word;
  assign hit = |way_hit;

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (way_hit[w]) hit_way = AGE_W'(w);
  end

  assign hit_line = lines[idx][hit_way];
  assign hit_word = word ? hit_line[63:32] : hit_line[31:0];

  // Lowest invalid way wins over the oldest way
  always_comb begin
    victim = '0;
    for (int w = WAYS-1; w >= 0; w--)
      if (ages[idx][w] == AGE_W'(WAYS-1)) victim = AGE_W'(w);
    for (int w = WAYS-1; w >= 0; w--)
      if (!valid[idx][w]) victim = AGE_W'(w);
  end

  logic armed, done, inv_pend, wr_done, fill_done;
  logic ready_c, hit_inc, miss_inc, touch_en, fill_en, wr_upd, start_rd, start_wr;
  logic [31:0]      rdata_c;
  logic [AGE_W-1:0] touch_way;

  assign done = armed && sram_ready;

  always_comb begin
    state_nx  = state;
    ready_c   = 1'b1;
    rdata_c   = '0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    touch_en  = 1'b0;
    touch_way = hit_way;
    fill_en   = 1'b0;
    wr_upd    = 1'b0;
    start_rd  = 1'b0;
    start_wr  = 1'b0;
    case (state)
      IDLE: begin
        if (wr_done) begin
          ready_c = 1'b1;
        end else if (MEM_W_EN) begin
          ready_c  = 1'b0;
          start_wr = 1'b1;
          state_nx = WR;
        end else if (MEM_R_EN) begin
          if (hit) begin
            rdata_c  = hit_word;
            touch_en = 1'b1;
            hit_inc  = !fill_done;
          end else begin
            ready_c  = 1'b0;
            miss_inc = 1'b1;
            start_rd = 1'b1;
            state_nx = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        ready_c = 1'b0;
        if (done) begin
          fill_en   = 1'b1;
          touch_en  = 1'b1;
          touch_way = victim;
          state_nx  = IDLE;
        end
      end
      WR: begin
        ready_c = 1'b0;
        if (done) begin
          wr_upd   = hit;
          touch_en = hit;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A filled way is aged as if it were the oldest, so ages stay a recency order
  logic [WAYS-1:0][AGE_W-1:0] age_nx;
  logic [AGE_W-1:0]           ref_age;
  always_comb begin
    age_nx  = ages[idx];
    ref_age = fill_en ? AGE_W'(WAYS-1) : ages[idx][touch_way];
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == touch_way)     age_nx[w] = '0;
      else if (ages[idx][w] < ref_age) age_nx[w] = ages[idx][w] + AGE_W'(1);
    end
  end

  assign ready = rst ? ready_c : 1'b1;
  assign rdata = rst ? rdata_c : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      valid        <= '0;
      ages         <= '0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
      sram_read    <= 1'b0;
      sram_write   <= 1'b0;
      sram_address <= '0;
      sram_wdata   <= '0;
      armed        <= 1'b0;
      inv_pend     <= 1'b0;
      wr_done      <= 1'b0;
      fill_done    <= 1'b0;
    end else begin
      state     <= state_nx;
      armed     <= (state != IDLE) && (state_nx == state);
      wr_done   <= (state == WR) && done;
      fill_done <= (state == RD_MISS) && done;
      if (hit_inc && hit_cnt != '1)   hit_cnt  <= hit_cnt + CNT_W'(1);
      if (miss_inc && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);

      if (start_rd) begin
        sram_read    <= 1'b1;
        sram_address <= 32'({address[ADDR_W-1:3], 3'b000});
      end else if (start_wr) begin
        sram_write   <= 1'b1;
        sram_address <= 32'(address);
        sram_wdata   <= wdata;
      end else if (done) begin
        sram_read  <= 1'b0;
        sram_write <= 1'b0;
      end

      if (state == IDLE) begin
        inv_pend <= 1'b0;
        if (inv) begin
          valid <= '0;
          ages  <= '0;
        end else if (touch_en) begin
          ages[idx] <= age_nx;
        end
      end else begin
        if (inv) inv_pend <= 1'b1;
        if (fill_en) valid[idx][victim] <= 1'b1;
        if (touch_en) ages[idx] <= age_nx;
        // An invalidate raised mid-transaction lands after the fill
        if (done && (inv || inv_pend)) begin
          valid    <= '0;
          ages     <= '0;
          inv_pend <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[idx][victim]  <= tag;
      lines[idx][victim] <= sram_rdata;
    end
    if (wr_upd) begin
      if (word) lines[idx][hit_way][63:32] <= wdata;
      else      lines[idx][hit_way][31:0]  <= wdata;
    end
  end
endmodule
